// File: rtl/syscall_read_string_pkg.sv
// Shared processor definitions for the read_string syscall handler: FSM states,
// syscall constants, default data-memory window and the request validity check.
package syscall_read_string_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        TERM  = 3'd3,
        DONE  = 3'd4
    } rsState_t;

    localparam logic [7:0]  NEWLINE             = 8'h0A;
    localparam logic [7:0]  SYSCALL_READ_STRING = 8'd8;
    localparam logic [31:0] DEFAULT_ADDR_LO     = 32'h7FF00000;
    localparam logic [31:0] DEFAULT_ADDR_HI     = 32'h7FFFFFFF;

    // The whole word span the buffer could touch must lie inside [lo, hi];
    // 33-bit arithmetic keeps a buffer that wraps past 2^32 from looking legal.
    function automatic logic requestRejected(
        input logic [31:0] addr,
        input logic [31:0] len,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [32:0] lastByte;
        lastByte = {1'b0, addr} + {1'b0, (len - 32'd1) & ~32'd3} + 33'd3;
        return (addr[1:0] != 2'b00) || (addr < lo) ||
               ((len != 32'd0) && (lastByte > {1'b0, hi}));
    endfunction

endpackage

// File: rtl/syscall_read_string_byte_packer.sv
// Assembles console bytes into a little-endian 32-bit word, one lane per byte.
module syscall_read_string_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  dataByte,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] laneReg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            laneReg <= 2'd0;
        end else if (load) begin
            laneReg <= laneReg + 2'd1;
        end
    end

    // Unfilled lanes stay zero so a short final word carries its own terminator.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneByte;
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    laneByte <= 8'h00;
                end else if (load && (laneReg == 2'(gi))) begin
                    laneByte <= dataByte;
                end
            end
            assign word[8*gi +: 8] = laneByte;
        end
    endgenerate

    assign full = (laneReg == 2'd3);

endmodule

// File: rtl/syscall_read_string.sv
// read_string syscall engine: streams console bytes into a data-memory buffer,
// newline-or-length terminated, always leaving a null terminator behind.
module syscall_read_string
    import syscall_read_string_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = DEFAULT_ADDR_LO,
    parameter logic [31:0] ADDR_HI = DEFAULT_ADDR_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sig_start,
    input  logic [31:0] buf_addr,
    input  logic [31:0] buf_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] char_count
);

    rsState_t    state;
    logic [31:0] addrReg;
    logic [31:0] lenReg;
    logic [31:0] countReg;
    logic        termReg;
    logic        lastFullReg;
    logic        errorReg;

    logic        accept;
    logic        byteTerminal;
    logic        startReq;
    logic        reqError;
    logic        packClear;
    logic        packFull;
    logic [31:0] packWord;

    assign startReq     = (state == IDLE) && sig_start;
    assign reqError     = requestRejected(buf_addr, buf_len, ADDR_LO, ADDR_HI);
    assign accept       = (state == RECV) && in_valid;
    assign byteTerminal = (in_data == NEWLINE) || ((countReg + 32'd1) == (lenReg - 32'd1));
    assign packClear    = startReq || (state == WRITE);

    syscall_read_string_byte_packer bytePacker (
        .clk      (clk),
        .reset    (reset),
        .clear    (packClear),
        .load     (accept),
        .dataByte (in_data),
        .word     (packWord),
        .full     (packFull)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addrReg     <= 32'd0;
            lenReg      <= 32'd0;
            countReg    <= 32'd0;
            termReg     <= 1'b0;
            lastFullReg <= 1'b0;
            errorReg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sig_start) begin
                        addrReg     <= buf_addr;
                        lenReg      <= buf_len;
                        countReg    <= 32'd0;
                        termReg     <= 1'b0;
                        lastFullReg <= 1'b0;
                        errorReg    <= reqError;
                        // A one-byte buffer only has room for the terminator.
                        if (reqError || (buf_len == 32'd0)) begin
                            state <= DONE;
                        end else if (buf_len == 32'd1) begin
                            state <= TERM;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        countReg    <= countReg + 32'd1;
                        termReg     <= byteTerminal;
                        lastFullReg <= packFull;
                        if (packFull || byteTerminal) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    addrReg <= addrReg + 32'd4;
                    if (!termReg) begin
                        state <= RECV;
                    end else if (lastFullReg) begin
                        state <= TERM;
                    end else begin
                        state <= DONE;
                    end
                end
                TERM:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they change only on clk.
    assign in_ready       = (state == RECV);
    assign busy           = (state == RECV) || (state == WRITE) || (state == TERM);
    assign mem_write      = (state == WRITE) || (state == TERM);
    assign mem_addr       = mem_write ? addrReg : 32'd0;
    assign mem_write_data = (state == WRITE) ? packWord : 32'd0;
    assign done           = (state == DONE);
    assign error          = (state == DONE) && errorReg;
    assign char_count     = countReg;

endmodule

// File: tb/tb_syscall_read_string.sv
// Randomized scoreboard bench for syscall_read_string with a string-level reference model.
module tb_syscall_read_string;

    localparam logic [31:0] LO = 32'h7FF00000;
    localparam logic [31:0] HI = 32'h7FFFFFFF;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          isDone;
        logic [31:0] a;
        logic [31:0] d;
        bit          err;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        sig_start;
    logic [31:0] buf_addr;
    logic [31:0] buf_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] char_count;

    int  tests = 0;
    int  fails = 0;
    int  doneCount = 0;
    ev_t sbq[$];

    syscall_read_string #(.ADDR_LO(LO), .ADDR_HI(HI)) dut (
        .clk            (clk),
        .reset          (reset),
        .sig_start      (sig_start),
        .buf_addr       (buf_addr),
        .buf_len        (buf_len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .char_count     (char_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bq_t toQ(input string s);
        bq_t q;
        foreach (s[i]) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: the stored string is the accepted characters plus a null,
    // zero-padded to whole words and written word by word from the base.
    function automatic void modelPush(input logic [31:0] addr, input logic [31:0] len,
                                      input bq_t str, output int n);
        bq_t buffer;
        longint unsigned lastB;
        bit err;
        ev_t ev;
        lastB = longint'(addr) + 4 * ((longint'(len) + 3) / 4) - 1;
        err = (addr % 4 != 0) || (addr < LO) || (len != 0 && lastB > longint'(HI));
        n = 0;
        if (!err && len != 0) begin
            while (longint'(n) < longint'(len) - 1 && n < str.size()) begin
                buffer.push_back(str[n]);
                n++;
                if (str[n-1] == 8'h0A) break;
            end
            buffer.push_back(8'h00);
            while (buffer.size() % 4 != 0) buffer.push_back(8'h00);
            for (int w = 0; w < buffer.size() / 4; w++) begin
                ev.isDone = 1'b0;
                ev.a = addr + 32'(4 * w);
                ev.d = {buffer[4*w+3], buffer[4*w+2], buffer[4*w+1], buffer[4*w]};
                ev.err = 1'b0;
                sbq.push_back(ev);
            end
        end
        ev.isDone = 1'b1;
        ev.a = 32'd0;
        ev.d = 32'(n);
        ev.err = err;
        sbq.push_back(ev);
    endfunction

    // Monitor: every DUT write or done pulse is matched against the queue head.
    always @(negedge clk) begin
        ev_t ev;
        if (mem_write) begin
            if (sbq.size() == 0 || sbq[0].isDone) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write actual=%h@%h required=none", mem_write_data, mem_addr);
            end else begin
                ev = sbq.pop_front();
                check("write_addr", mem_addr, ev.a);
                check("write_data", mem_write_data, ev.d);
                $display("[TB] write addr=%h data=%h", mem_addr, mem_write_data);
            end
        end
        if (done) begin
            doneCount++;
            if (sbq.size() == 0 || !sbq[0].isDone) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done actual=done required=%0s",
                         sbq.size() == 0 ? "none" : "write");
            end else begin
                ev = sbq.pop_front();
                check("done_error", 32'(error), 32'(ev.err));
                check("char_count", char_count, ev.d);
                $display("[TB] done error=%0b char_count=%0d", error, char_count);
            end
            check("busy_at_done", 32'(busy), 32'd0);
        end
        if (in_ready) begin
            check("busy_in_recv", 32'(busy), 32'd1);
        end
    end

    // validPct<0 toggles in_valid every other cycle; resetAfter>=0 aborts with reset
    // that many cycles after the first accepted byte.
    task automatic runTxn(input logic [31:0] addr, input logic [31:0] len, input bq_t str,
                          input int validPct, input bit midStart, input int resetAfter);
        bq_t stream;
        int  expN;
        int  accepted = 0;
        int  cyc = 0;
        int  firstAcc = -1;
        int  startDone;
        int  busyLow = 0;
        bit  aborted = 0;
        stream = str;
        expN = 0;
        if (resetAfter < 0) modelPush(addr, len, str, expN);
        startDone = doneCount;
        @(negedge clk); #1;
        sig_start = 1'b1;
        buf_addr  = addr;
        buf_len   = len;
        @(negedge clk); #1;
        sig_start = 1'b0;
        while (doneCount == startDone && cyc < 2000) begin
            if (validPct < 0) in_valid = (stream.size() > 0) && (cyc % 2 == 0);
            else              in_valid = (stream.size() > 0) && ($urandom_range(0, 99) < validPct);
            in_data = in_valid ? stream[0] : 8'($urandom);
            if (midStart && cyc == 3 && busy) begin
                sig_start = 1'b1;
                buf_addr  = 32'h7FF00200;
                buf_len   = 32'd8;
            end else begin
                sig_start = 1'b0;
            end
            if (!busy) busyLow++;
            if (in_valid && in_ready) begin
                void'(stream.pop_front());
                accepted++;
                if (firstAcc < 0) firstAcc = cyc;
            end
            if (resetAfter >= 0 && firstAcc >= 0 && cyc == firstAcc + resetAfter) begin
                reset = 1'b1;
                aborted = 1;
                break;
            end
            @(negedge clk); #1;
            cyc++;
        end
        sig_start = 1'b0;
        if (aborted) begin
            @(negedge clk); #1;
            reset = 1'b0;
            in_valid = 1'b0;
            check("abort_ctrl", 32'({in_ready, mem_write, busy, done, error}), 32'd0);
            check("abort_addr", mem_addr, 32'd0);
            check("abort_data", mem_write_data, 32'd0);
            check("abort_count", char_count, 32'd0);
            repeat (10) @(negedge clk);
            #1;
            check("abort_no_done", 32'(doneCount), 32'(startDone));
        end else begin
            in_valid = 1'b0;
            if (cyc >= 2000) begin
                tests++;
                fails++;
                $display("FAIL timeout actual=%0d cycles required=done", cyc);
                sbq.delete();
            end
            check("bytes_accepted", 32'(accepted), 32'(expN));
            check("scoreboard_empty", 32'(sbq.size()), 32'd0);
            if (midStart) check("busy_throughout", 32'(busyLow), 32'd0);
            $display("[TB] txn addr=%h len=%0d accepted=%0d", addr, len, accepted);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] len;
        int nChars;
        bit withNl;
        bq_t s;
        reset = 1'b1;
        sig_start = 1'b0;
        buf_addr = 32'd0;
        buf_len = 32'd0;
        in_valid = 1'b0;
        in_data = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", 32'({in_ready, mem_write, busy, done, error}), 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_data", mem_write_data, 32'd0);
        check("reset_count", char_count, 32'd0);
        reset = 1'b0;

        runTxn(32'h7FF00100, 32'd16, toQ("abc\n"), 100, 0, -1);
        runTxn(32'h7FF00100, 32'd5, toQ("wxyzQRS"), 100, 0, -1);
        runTxn(32'h7FF00102, 32'd16, toQ("abc\n"), 100, 0, -1);
        runTxn(32'h7FFFFFF8, 32'd16, toQ("abc\n"), 100, 0, -1);
        runTxn(32'h7FF00100, 32'd0, toQ("zz\n"), 100, 0, -1);
        runTxn(32'h7FF00100, 32'd1, toQ("zz\n"), 100, 0, -1);
        runTxn(32'h7FF00100, 32'd16, toQ("hi\n"), -1, 1, -1);
        runTxn(32'h7FF00100, 32'd16, toQ("abcdef\n"), 100, 0, 2);
        runTxn(32'h7FF00100, 32'd16, toQ("abc\n"), 100, 0, -1);

        for (int t = 0; t < 25; t++) begin
            len = 32'($urandom_range(0, 13));
            case ($urandom_range(0, 9))
                6:       addr = LO + 32'($urandom_range(0, 4095) * 4) + 32'($urandom_range(1, 3));
                7:       addr = 32'h80000000 - 32'(4 * $urandom_range(1, 5));
                8:       addr = LO - 32'(4 * $urandom_range(1, 16));
                9:       addr = LO;
                default: addr = LO + 32'($urandom_range(0, 4095) * 4);
            endcase
            withNl = 1'($urandom_range(0, 1));
            nChars = withNl ? $urandom_range(0, 14) : int'(len) + 2;
            s = {};
            for (int i = 0; i < nChars; i++) s.push_back(8'($urandom_range(32'h20, 32'h7E)));
            if (withNl) s.push_back(8'h0A);
            s.push_back(8'h51);
            runTxn(addr, len, s, $urandom_range(30, 100), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/syscall_read_string.md
SYSCALL_READ_STRING -- requirements
Module: syscall_read_string

Interface
REQ-001 Parameter ADDR_LO, default 32'h7FF00000, lowest legal data-memory byte address.
REQ-002 Parameter ADDR_HI, default 32'h7FFFFFFF, highest legal data-memory byte address.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sig_start  in  1  one-cycle request: read_string syscall (v0=8) in M stage.
REQ-006 buf_addr  in  32  buffer base address (a0), sampled with sig_start.
REQ-007 buf_len  in  32  buffer size in bytes (a1), sampled with sig_start.
REQ-008 in_valid  in  1  console byte available.
REQ-009 in_data  in  8  console byte.
REQ-010 in_ready  out  1  block accepts in_data this cycle.
REQ-011 mem_write  out  1  one-cycle word write strobe to data memory.
REQ-012 mem_addr  out  32  word-aligned write address.
REQ-013 mem_write_data  out  32  write word; byte k of the buffer goes to bits [8k+7:8k] (little-endian lanes).
REQ-014 busy  out  1  stall request to the hazard unit.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 error  out  1  valid with done; request rejected, nothing written.
REQ-017 char_count  out  32  console bytes stored; valid from done until the next accepted start.

Function
REQ-018 States SHALL be IDLE, RECV, WRITE, TERM, DONE.
REQ-019 In IDLE, sig_start SHALL latch buf_addr, buf_len and clear count, lane and word; sig_start outside IDLE SHALL be ignored.
REQ-020 Validity check at start:
- misaligned if buf_addr[1:0]!=0;
- out of range if buf_addr<ADDR_LO, or if (33-bit) buf_addr+4*floor((buf_len-1)/4)+3>ADDR_HI for buf_len>=1.
- Either condition SHALL go to DONE with error=1 and no writes.
REQ-021 Otherwise: buf_len==0 -> DONE, no writes; buf_len==1 -> TERM; else -> RECV.
REQ-022 busy SHALL be 1 in RECV, WRITE and TERM, and 0 in IDLE and DONE.
REQ-023 in_ready SHALL equal 1 only in RECV.
REQ-024 A byte is accepted when in_valid and in_ready are both 1. On acceptance it SHALL be placed in the current lane, and both lane and count SHALL increment.
REQ-025 The accepted byte is terminal if it equals 8'h0A (newline, stored) or count reaches buf_len-1.
REQ-026 After acceptance, the FSM SHALL go to WRITE if the lane was 3 or the byte is terminal; otherwise it stays in RECV.
REQ-027 WRITE:
- mem_write=1 for exactly one cycle; mem_addr = current address; mem_write_data = word with unfilled lanes 0.
- Then address += 4, word cleared, lane cleared.
REQ-028 WRITE successor:
- not terminal -> RECV;
- terminal and last byte in lane 3 -> TERM;
- terminal otherwise -> DONE (zero padding is the null terminator).
REQ-029 TERM SHALL write 32'h0 at the current address for one cycle, then go to DONE.
REQ-030 DONE SHALL pulse done=1 for one cycle with error and char_count valid, then go to IDLE.
REQ-031 mem_write SHALL never be 1 outside WRITE and TERM. At most ceil(buf_len/4) writes SHALL occur, all within [buf_addr, buf_addr+4*ceil(buf_len/4)-1].
REQ-032 Absence of in_valid SHALL hold RECV indefinitely with busy=1. There is no timeout.
REQ-033 Latency: a terminal byte accepted in cycle N gives the word write in N+1, a TERM write (if required) in N+2, and done in the following cycle.

Reset
REQ-034 reset SHALL force IDLE and zero all outputs, counters, lanes and latched inputs on the next posedge. Outputs: in_ready, mem_write, mem_addr, mem_write_data, busy, done, error, char_count all 0.
REQ-035 reset during RECV, WRITE or TERM SHALL abort with no further writes and no done pulse.
REQ-036 reset asserted together with sig_start SHALL take priority; the start is dropped.

Structure
REQ-037 The state encoding, the NEWLINE constant (8'h0A), the syscall code SYSCALL_READ_STRING=8 and default ADDR_LO/ADDR_HI SHALL live in the shared processor package used by the syscall handler.
REQ-038 One sub-module, byte_packer, SHALL hold the lane counter and 32-bit assembly word (load-lane, clear, full flag). All else is in the FSM.

Verification
REQ-039 buf_addr=32'h7FF00100, buf_len=16, bytes "abc\n":
- one write at 7FF00100 = 32'h0A636261;
- done after it, char_count=4, error=0.
REQ-040 buf_len=5, bytes "wxyzQ...":
- write 7FF00100 = 32'h7A797877 (wxyz), then TERM write 7FF00104 = 0;
- char_count=4; Q is never accepted (in_ready low).
REQ-041 buf_addr=32'h7FF00102 -> done+error next cycle, no mem_write. buf_addr=32'h7FFFFFF8 with buf_len=16 -> error.
REQ-042 buf_len=0 -> done, no writes. buf_len=1 -> single write of 0 at buf_addr.
REQ-043 Backpressure: in_valid toggled every other cycle for "hi\n":
- one write 32'h000A6968;
- busy high throughout; a second sig_start mid-transfer is ignored.
REQ-044 reset asserted two cycles after the first byte of "abcdef\n":
- no mem_write after reset, no done, all outputs 0;
- a new start afterwards behaves per REQ-039.
